regfile_mp: RTL

Parametrised two-read/one-write register file. It is the CPU register-file successor to the single-read 32x32 array. Over the old array it adds:
- configurable width and depth
- hardwired zero register
- same-cycle write-to-read bypass
- per-register pending scoreboard for the issue stage
- self-clearing sequence after reset

It sits between decode (read/lock) and writeback (write).

---
 rtl/regfile_mp.sv | 106 ++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Two-read/one-write register file with write bypass, per-register pending
// scoreboard and a post-reset clearing sweep that holds busy for DEPTH cycles.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    rd1_addr,
  output logic [WIDTH-1:0] rd1_data,
  output logic             rd1_pending,
  input  logic [AW-1:0]    rd2_addr,
  output logic [WIDTH-1:0] rd2_data,
  output logic             rd2_pending,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             lock_en,
  input  logic [AW-1:0]    lock_addr,
  output logic             busy
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e           state_q;
  logic [AW-1:0]    clr_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;
  logic             wr_ok_s;
  logic             lock_ok_s;

  // Register 0 (when hardwired) and addresses past the end never hold state.
  function automatic logic writable(input logic [AW-1:0] a);
    return (({1'b0, a}) < (AW+1)'(DEPTH)) && !(ZERO_REG && (a == {AW{1'b0}}));
  endfunction

  assign busy      = (state_q == CLEAR);
  assign wr_ok_s   = wr_en   && (state_q == READY) && writable(wr_addr);
  assign lock_ok_s = lock_en && (state_q == READY) && writable(lock_addr);

  // Lock wins over a same-cycle writeback: a newer producer has been issued.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < DEPTH; i++) begin
      pending_d[i] = (lock_ok_s && (lock_addr == AW'(i))) ||
                     (pending_q[i] && !(wr_ok_s && (wr_addr == AW'(i))));
    end
  end

  // Control FSM: clear sweep pointer, state and scoreboard.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= {AW{1'b0}};
      pending_q <= {DEPTH{1'b0}};
    end else if (state_q == CLEAR) begin
      clr_ptr_q <= clr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      if (clr_ptr_q == LAST_IDX) begin
        state_q <= READY;
      end
    end else begin
      pending_q <= pending_d;
    end
  end

  // Storage array: zeroed one entry per cycle by the sweep, else written back.
  always_ff @(posedge clock) begin
    if (!reset && (state_q == CLEAR)) begin
      mem_q[clr_ptr_q] <= {WIDTH{1'b0}};
    end else if (!reset && wr_ok_s) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read port 1 with same-cycle bypass; the bypassed value counts as ready.
  always_comb begin
    rd1_data    = {WIDTH{1'b0}};
    rd1_pending = 1'b0;
    if ((state_q == READY) && writable(rd1_addr)) begin
      rd1_data    = (wr_ok_s && (wr_addr == rd1_addr)) ? wr_data : mem_q[rd1_addr];
      rd1_pending = pending_q[rd1_addr] && !(wr_en && (wr_addr == rd1_addr));
    end else begin
      rd1_data    = {WIDTH{1'b0}};
      rd1_pending = 1'b0;
    end
  end

  // Read port 2, identical to port 1.
  always_comb begin
    rd2_data    = {WIDTH{1'b0}};
    rd2_pending = 1'b0;
    if ((state_q == READY) && writable(rd2_addr)) begin
      rd2_data    = (wr_ok_s && (wr_addr == rd2_addr)) ? wr_data : mem_q[rd2_addr];
      rd2_pending = pending_q[rd2_addr] && !(wr_en && (wr_addr == rd2_addr));
    end else begin
      rd2_data    = {WIDTH{1'b0}};
      rd2_pending = 1'b0;
    end
  end

endmodule
